simple_bus_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing the simple_bus memory slave among NUM_REQ requesters.

---
 rtl/simple_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_simple_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter sharing one simple_bus memory slave among NUM_REQ requesters.
// One command in flight at a time; reads that never see m_rvalid return an error response.
module simple_bus_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic                        m_req,
  output logic                        m_we,
  output logic [ADDR_W-1:0]           m_waddr,
  output logic [DATA_W-1:0]           m_wdata,
  output logic                        m_re,
  output logic [ADDR_W-1:0]           m_raddr,
  input  logic [DATA_W-1:0]           m_rdata,
  input  logic                        m_rvalid,
  output logic                        busy
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StRdWait, StRsp} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     rr_ptr_q, owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                gnt_found;
  logic [PtrW-1:0]     gnt_idx;
  logic [PtrW-1:0]     scan_idx;
  logic                accept;

  // Scan starting at rr_ptr; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = PtrW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign accept = (state_q == StIdle) && gnt_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_re      = 1'b0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) state_d = req_we[gnt_idx] ? StWr : StRd;
      end
      StWr: begin
        m_req              = 1'b1;
        m_we               = 1'b1;
        rsp_valid[owner_q] = 1'b1;
        state_d            = StIdle;
      end
      StRd: begin
        m_req   = 1'b1;
        m_re    = 1'b1;
        cnt_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        cnt_d = cnt_q + 1'b1;
        if (m_rvalid) begin
          rdata_d = m_rdata;
          err_d   = 1'b0;
          state_d = StRsp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StRsp;
        end
      end
      StRsp: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_data           = rdata_q;
        rsp_err            = err_q;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        owner_q  <= gnt_idx;
        addr_q   <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
        wdata_q  <= req_wdata[gnt_idx*DATA_W +: DATA_W];
        rr_ptr_q <= (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Address/data pins just hold the latched command; the strobes qualify them.
  assign m_waddr = addr_q;
  assign m_raddr = addr_q;
  assign m_wdata = wdata_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Bench for simple_bus_arbiter: per-requester command queues, a memory slave model and a
// per-owner scoreboard of expected responses (data, error flag, latency from accept).
module tb_simple_bus_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*8-1:0]  req_addr;
  logic [N*32-1:0] req_wdata;
  logic [31:0]     rsp_data, m_wdata, m_rdata;
  logic            rsp_err, m_req, m_we, m_re, m_rvalid, busy;
  logic [7:0]      m_waddr, m_raddr;

  simple_bus_arbiter #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .m_req(m_req), .m_we(m_we), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .m_re(m_re), .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } cmd_t;

  typedef struct {
    int          id;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    logic        stall;
  } vec_t;

  cmd_t        cq[N][32];
  int          acc_cyc[N][32];
  int          ch[N], ct[N], rh[N];
  logic        acc[N];
  logic [31:0] smem[256];
  int          glog_id[64], glog_cyc[64];
  int          gn;
  int          cyc;
  logic        stall, inj, rd_pend;
  logic [7:0]  rd_addr;
  int          n_checks, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int i, input logic we, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_err, input int exp_lat);
    cq[i][ct[i]] = '{we, addr, wdata, exp_data, exp_err, exp_lat};
    ct[i]++;
  endtask

  task automatic wait_done(input int i, input int lim);
    int n = 0;
    while (rh[i] < ct[i] && n < lim) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (rh[i] < ct[i]) begin
      n_fail++;
      $display("FAIL wait_done req%0d: %0d responses outstanding after %0d cycles",
               i, ct[i] - rh[i], lim);
      rh[i] = ct[i];
    end
  endtask

  // Slave model, response monitor and requester drivers.
  initial begin : agent
    int o;
    for (int a = 0; a < 256; a++) smem[a] = '0;
    rd_pend = 1'b0;
    rd_addr = '0;
    cyc     = 0;
    forever begin
      @(negedge clk);
      cyc++;
      check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      check("ready_while_busy", 32'(busy && (req_ready != '0)), 32'd0);
      if (rsp_valid != '0) begin
        if ($countones(rsp_valid) != 1) begin
          check("rsp_valid_onehot", 32'(rsp_valid), 32'd0);
        end else begin
          o = 0;
          for (int k = 0; k < N; k++) if (rsp_valid[k]) o = k;
          if (rh[o] >= ch[o]) begin
            check($sformatf("unexpected_rsp_req%0d", o), 32'(rsp_valid), 32'd0);
          end else begin
            check($sformatf("rsp_data_req%0d", o), rsp_data, cq[o][rh[o]].exp_data);
            check($sformatf("rsp_err_req%0d", o), 32'(rsp_err), 32'(cq[o][rh[o]].exp_err));
            check($sformatf("rsp_lat_req%0d", o), 32'(cyc - acc_cyc[o][rh[o]]),
                  32'(cq[o][rh[o]].exp_lat));
            rh[o]++;
          end
        end
      end
      if (m_we) smem[m_waddr] = m_wdata;
      if (m_re) begin
        rd_pend = 1'b1;
        rd_addr = m_raddr;
      end
      for (int i = 0; i < N; i++) begin
        acc[i] = rst_n && req_ready[i] && req_valid[i];
        if (acc[i]) begin
          acc_cyc[i][ch[i]] = cyc;
          glog_id[gn]       = i;
          glog_cyc[gn]      = cyc;
          gn++;
        end
      end
      @(posedge clk);
      #1;
      m_rvalid = (rd_pend && !stall) || inj;
      m_rdata  = rd_pend ? smem[rd_addr] : 32'hBAD0_0000;
      rd_pend  = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) ch[i]++;
        req_valid[i] = (ch[i] < ct[i]);
        if (ch[i] < ct[i]) begin
          req_we[i]             = cq[i][ch[i]].we;
          req_addr[i*8 +: 8]    = cq[i][ch[i]].addr;
          req_wdata[i*32 +: 32] = cq[i][ch[i]].wdata;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : test
    vec_t tbl[8];
    tbl[0] = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1,  1'b0};
    tbl[1] = '{0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3,  1'b0};
    tbl[2] = '{3, 1'b1, 8'hFF, 32'h12345678, 32'h0,        1'b0, 1,  1'b0};
    tbl[3] = '{3, 1'b0, 8'hFF, 32'h0,        32'h12345678, 1'b0, 3,  1'b0};
    tbl[4] = '{1, 1'b0, 8'h00, 32'h0,        32'h0,        1'b0, 3,  1'b0};
    tbl[5] = '{0, 1'b1, 8'h10, 32'hA5A5A5A5, 32'h0,        1'b0, 1,  1'b0};
    tbl[6] = '{2, 1'b0, 8'h10, 32'h0,        32'hA5A5A5A5, 1'b0, 3,  1'b0};
    tbl[7] = '{2, 1'b0, 8'h20, 32'h0,        32'h0,        1'b1, 17, 1'b1};

    n_checks = 0; n_fail = 0; gn = 0;
    for (int i = 0; i < N; i++) begin ch[i] = 0; ct[i] = 0; rh[i] = 0; acc[i] = 1'b0; end
    rst_n = 1'b0; stall = 1'b0; inj = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    m_rvalid = 1'b0; m_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_strobes", 32'({m_req, m_we, m_re}), 32'd0);
    check("reset_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    rst_n = 1'b1;

    // Single commands, including the read timeout.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      stall = tbl[v].stall;
      issue(tbl[v].id, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].exp_data,
            tbl[v].exp_err, tbl[v].exp_lat);
      wait_done(tbl[v].id, 40);
      stall = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", v), 32'(busy), 32'd0);
      if (tbl[v].we) check($sformatf("vec%0d_slave_mem", v), smem[tbl[v].addr], tbl[v].wdata);
    end

    // Stray m_rvalid while idle and during a write.
    inj = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_rvalid_idle", 32'(busy), 32'd0);
    end
    issue(0, 1'b1, 8'h50, 32'h0BADF00D, 32'h0, 1'b0, 1);
    wait_done(0, 20);
    inj = 1'b0;
    @(negedge clk);
    check("stray_rvalid_wr_idle", 32'(busy), 32'd0);
    check("stray_rvalid_wr_mem", smem[8'h50], 32'h0BADF00D);

    // Reset during RD_WAIT abandons the read.
    stall = 1'b1;
    issue(1, 1'b0, 8'h30, 32'h0, 32'h0, 1'b1, 17);
    repeat (6) @(negedge clk);
    check("rdwait_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({m_req, m_we, m_re}), 32'd0);
    check("rst_addr", 32'({m_waddr, m_raddr}), 32'd0);
    check("rst_wdata", m_wdata, 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rh[1] = ch[1];
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (20) @(negedge clk);
    gn = 0;
    issue(3, 1'b0, 8'hFF, 32'h0, 32'h12345678, 1'b0, 3);
    issue(2, 1'b0, 8'h10, 32'h0, 32'hA5A5A5A5, 1'b0, 3);
    wait_done(2, 30);
    wait_done(3, 30);
    check("post_rst_first_grant", 32'(glog_id[0]), 32'd2);
    check("post_rst_second_grant", 32'(glog_id[1]), 32'd3);

    // All four requesters hold writes: strict rotation, one grant every 2 cycles.
    @(negedge clk);
    gn = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        issue(i, 1'b1, 8'(8'h40 + i * 2 + k), 32'hC0DE0000 + 32'(i * 16 + k), 32'h0, 1'b0, 1);
    for (int i = 0; i < N; i++) wait_done(i, 40);
    check("rr_grant_count", 32'(gn), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr_order%0d", k), 32'(glog_id[k]), 32'(k % N));
      if (k > 0) check($sformatf("rr_spacing%0d", k), 32'(glog_cyc[k] - glog_cyc[k-1]), 32'd2);
    end
    check("rr_mem_req3", smem[8'h47], 32'hC0DE0031);

    // req1 and req3 reading continuously: alternation, each response to its owner.
    @(negedge clk);
    gn = 0;
    for (int k = 0; k < 3; k++) begin
      issue(1, 1'b0, 8'h10, 32'h0, 32'hA5A5A5A5, 1'b0, 3);
      issue(3, 1'b0, 8'hFF, 32'h0, 32'h12345678, 1'b0, 3);
    end
    wait_done(1, 60);
    wait_done(3, 60);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("alt_order%0d", k), 32'(glog_id[k]), (k % 2 == 0) ? 32'd1 : 32'd3);
      if (k > 0) check($sformatf("alt_spacing%0d", k), 32'(glog_cyc[k] - glog_cyc[k-1]), 32'd4);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
